counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Run controller for a free-standing up-counter: sequences start, hold, stop and restart of the count, and selects one-shot (saturate) or periodic (wrap) behaviour against a run-time terminal count. Sits between control logic (FSMs, register file) and any datapath needing a timed window or periodic strobe. Replaces hard-coded fixed-limit counters with one programmable, supervised instance.

## Interface
- CNT_W, 7, counter width; limits 1..2^CNT_W-1
- PRESCALE_W, 4, prescaler divide-field width (used only with COUNTER_CTRL_PRESCALE_EN)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_start  in  1  pulse; (re)start a count
- i_stop  in  1  pulse; abort, return to IDLE
- i_hold  in  1  level; freeze count while high
- i_mode  in  1  0 = one-shot, 1 = periodic; sampled at start
- i_limit  in  CNT_W  terminal count L; sampled at start
- i_div  in  PRESCALE_W  tick divide (present only with COUNTER_CTRL_PRESCALE_EN)
- o_cnt  out  CNT_W  current count
- o_busy  out  1  high in RUN or HOLD
- o_tc  out  1  terminal-count strobe
- o_done  out  1  high in DONE

## Operation
- States: IDLE, RUN, HOLD, DONE. Reset -> IDLE, o_cnt=0, o_busy=0, o_tc=0, o_done=0.
- Input priority per cycle: reset > i_stop > i_start > i_hold.
- Start: i_start with i_limit != 0 in any state -> RUN, o_cnt=0, latch L and mode. i_limit==0: start ignored, state unchanged.
- Stop: i_stop in any state -> IDLE, o_cnt=0. Start+stop same cycle: stop wins.
- RUN: each tick o_cnt += 1 while o_cnt < L-1. At o_cnt==L-1 on a tick: one-shot -> DONE, o_cnt holds L-1; periodic -> o_cnt=0, stays RUN.
- o_tc = (state==RUN) & tick & (o_cnt==L-1) & !i_hold & !i_stop & !i_start; decoded from registers, no added latency.
- HOLD: RUN & i_hold -> HOLD, no increment that cycle. HOLD & !i_hold -> RUN, no increment that cycle; increments resume on the following tick. o_cnt frozen throughout.
- DONE: o_done=1, o_cnt=L-1; exit only by i_start or i_stop. i_hold ignored in IDLE and DONE.
- Arithmetic: compare against latched L, never live i_limit; o_cnt never exceeds L-1, no overflow for any legal L.

## Timing
- i_start at edge N -> state RUN, o_cnt=0 from N+1.
- Tick every cycle (no prescaler): L=100 one-shot -> o_cnt 0..99 over N+1..N+100, o_tc high at N+100, DONE with o_cnt=99 from N+101.
- Periodic L=100: o_cnt 99 -> 0, o_tc once every 100 cycles, no dead cycle.
- L=1: o_cnt stays 0; o_tc every tick in periodic; one-shot reaches DONE after one tick.
- Restart mid-run or in DONE: count resets, new L/mode take effect immediately.

## Configuration
- COUNTER_CTRL_PRESCALE_EN defined: i_div port present; internal prescaler issues tick every i_div+1 cycles; prescaler cleared on start, stop, and on HOLD exit; o_tc asserts only in tick cycles.
- Not defined: no i_div port, no prescaler logic, tick=1 every cycle.

## Structure
- Package counter_ctrl_pkg: state enum typedef (IDLE/RUN/HOLD/DONE), mode encodings (MODE_ONESHOT=0, MODE_PERIODIC=1), default CNT_W/PRESCALE_W constants.
- One sub-module counter_core: clear, enable, terminal value, wrap select; outputs count and at-terminal flag. FSM and prescaler stay in counter_ctrl.

## Test plan
- Reset asserted mid-RUN at o_cnt=42 -> next cycle IDLE, all outputs 0.
- One-shot L=100, start -> o_tc single pulse at o_cnt=99, then o_done=1, o_cnt=99 held 20 cycles.
- Periodic L=5 for 20 cycles -> o_cnt 0,1,2,3,4,0..., o_tc exactly 4 pulses, o_busy=1 throughout.
- i_hold high 3 cycles at o_cnt=10 (L=50) -> o_cnt=10 for 4 cycles (enter + 3 hold/exit), then 11.
- i_start and i_stop same cycle in RUN -> IDLE, o_cnt=0; i_start with i_limit=0 in IDLE -> stays IDLE.
- With COUNTER_CTRL_PRESCALE_EN, i_div=3, periodic L=4 -> o_cnt advances every 4 cycles, o_tc every 16 cycles.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter run controller.
// No logic; consumed by counter_ctrl and counter_core.
// No flow control.
package counter_ctrl_pkg;

    localparam int CNT_W_DEF      = 7;
    localparam int PRESCALE_W_DEF = 4;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_ctrl_core.sv
// Up-counter with clear, enable, terminal value and wrap/saturate select.
// Latency: count updates one cycle after enable; at_term is combinational from the count.
// No backpressure; enable is a plain qualifier.
import counter_ctrl_pkg::*;

module counter_core #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    input  logic             wrap,
    output logic [CNT_W-1:0] cnt,
    output logic             at_term
);

    assign at_term = (cnt == term);

    // Count up to term, then either wrap to zero or saturate at term.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (!at_term) begin
                cnt <= cnt + CNT_W'(1);
            end else if (wrap) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run controller (IDLE/RUN/HOLD/DONE) for a one-shot or periodic up-counter; optional prescaler under COUNTER_CTRL_PRESCALE_EN.
// Latency: start at edge N gives RUN with o_cnt=0 from N+1; o_tc is decoded combinationally in the terminal tick cycle.
// No backpressure; i_hold freezes the count, i_stop/i_start preempt everything except reset.
import counter_ctrl_pkg::*;

module counter_ctrl #(
`ifdef COUNTER_CTRL_PRESCALE_EN
    parameter int PRESCALE_W = PRESCALE_W_DEF,
`endif
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_hold,
    input  logic                  i_mode,
    input  logic [CNT_W-1:0]      i_limit,
`ifdef COUNTER_CTRL_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] i_div,
`endif
    output logic [CNT_W-1:0]      o_cnt,
    output logic                  o_busy,
    output logic                  o_tc,
    output logic                  o_done
);

    state_t           state;
    logic [CNT_W-1:0] lim_m1;
    logic             mode_q;
    logic             tick;
    logic             at_term;
    logic             start_eff;
    logic             core_en;

    // A zero limit is not a legal run length, so such a start is dropped.
    assign start_eff = i_start && (i_limit != '0);

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == i_div);

    // Prescaler runs only while counting; any (re)entry to RUN starts a fresh period.
    always_ff @(posedge clk) begin
        if (reset || i_stop || start_eff || (state != RUN) || i_hold) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign core_en = (state == RUN) && tick && !i_hold && !i_stop && !start_eff;

    assign o_tc = (state == RUN) && tick && at_term && !i_hold && !i_stop && !i_start;

    counter_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (i_stop || start_eff),
        .en      (core_en),
        .term    (lim_m1),
        .wrap    (mode_q == MODE_PERIODIC),
        .cnt     (o_cnt),
        .at_term (at_term)
    );

    // Run-control FSM: latches limit/mode on start and keeps busy/done registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            lim_m1 <= '0;
            mode_q <= MODE_ONESHOT;
        end else if (i_stop) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else if (start_eff) begin
            state  <= RUN;
            o_busy <= 1'b1;
            o_done <= 1'b0;
            lim_m1 <= i_limit - CNT_W'(1);
            mode_q <= i_mode;
        end else begin
            case (state)
                RUN: begin
                    if (i_hold) begin
                        state <= HOLD;
                    end else if (tick && at_term && (mode_q == MODE_ONESHOT)) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!i_hold) begin
                        state <= RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
`timescale 1ns/1ps
module tb_counter_ctrl;

    localparam int CNT_W      = 7;
    localparam int PRESCALE_W = 4;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             i_start = 1'b0;
    logic             i_stop  = 1'b0;
    logic             i_hold  = 1'b0;
    logic             i_mode  = 1'b0;
    logic [CNT_W-1:0] i_limit = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [PRESCALE_W-1:0] i_div = '0;
`endif
    logic [CNT_W-1:0] o_cnt;
    logic             o_busy;
    logic             o_tc;
    logic             o_done;

    always #5 clk = ~clk;

    counter_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_stop  (i_stop),
        .i_hold  (i_hold),
        .i_mode  (i_mode),
        .i_limit (i_limit),
`ifdef COUNTER_CTRL_PRESCALE_EN
        .i_div   (i_div),
`endif
        .o_cnt   (o_cnt),
        .o_busy  (o_busy),
        .o_tc    (o_tc),
        .o_done  (o_done)
    );

    typedef struct {
        int cnt;
        bit busy;
        bit tc;
        bit done;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;
    int   cur_div  = 0;

    // Reference model: a run is "n ticks since start" against length L.
    bit m_active = 0;
    bit m_held   = 0;
    bit m_per    = 0;
    int m_n      = 0;
    int m_L      = 0;
    int m_pre    = 0;
    int m_div    = 0;

    function automatic bit m_done();
        return m_active && !m_per && (m_n >= m_L);
    endfunction

    function automatic int m_cnt();
        if (!m_active) return 0;
        if (m_per) return m_n % m_L;
        return (m_n >= m_L) ? m_L - 1 : m_n;
    endfunction

    function automatic bit m_tick();
`ifdef COUNTER_CTRL_PRESCALE_EN
        return m_pre == m_div;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req, input int c);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, c, act, req);
        end
    endtask

    // One stimulus cycle: drive, predict this cycle's outputs, then advance the model.
    task automatic cyc(input bit rst, input bit st, input bit sp, input bit hd,
                       input bit md, input int lim, input int dv);
        exp_t e;
        bit   running;
        @(posedge clk);
        #1;
        reset   = rst;
        i_start = st;
        i_stop  = sp;
        i_hold  = hd;
        i_mode  = md;
        i_limit = CNT_W'(lim);
`ifdef COUNTER_CTRL_PRESCALE_EN
        i_div   = PRESCALE_W'(dv);
`endif
        m_div   = dv;
        cyc_no++;
        running = m_active && !m_held && !m_done();
        e.cnt   = m_cnt();
        e.busy  = m_active && !m_done();
        e.done  = m_done();
        e.tc    = running && m_tick() && (m_cnt() == m_L - 1) && !hd && !sp && !st;
        e.cyc   = cyc_no;
        sb.push_back(e);
        if (rst || sp) begin
            m_active = 0; m_held = 0; m_n = 0; m_pre = 0;
        end else if (st && lim != 0) begin
            m_active = 1; m_held = 0; m_n = 0; m_pre = 0; m_L = lim; m_per = md;
        end else if (running) begin
            if (hd) begin
                m_held = 1; m_pre = 0;
            end else if (m_tick()) begin
                m_n++; m_pre = 0;
            end else begin
                m_pre++;
            end
        end else if (m_active && m_held && !hd) begin
            m_held = 0; m_pre = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, cur_div);
    endtask

    // Monitor: compare every presented output against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("o_cnt",  32'(o_cnt),  32'(e.cnt),  e.cyc);
            check("o_busy", 32'(o_busy), 32'(e.busy), e.cyc);
            check("o_tc",   32'(o_tc),   32'(e.tc),   e.cyc);
            check("o_done", 32'(o_done), 32'(e.done), e.cyc);
        end
    end

    initial begin
        bit hold_lvl;
        bit rr, ss, pp;
        int lim;
        hold_lvl = 0;

        // Reset state.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // One-shot L=100: single tc at 99, then DONE held for 20+ cycles.
        cyc(0, 1, 0, 0, 0, 100, cur_div);
        idle(125);

        // Periodic L=5 for 20 cycles.
        cyc(0, 1, 0, 0, 1, 5, cur_div);
        idle(20);

        // Hold for 3 cycles at o_cnt=10 with L=50.
        cyc(0, 1, 0, 0, 0, 50, cur_div);
        idle(10);
        repeat (3) cyc(0, 0, 0, 1, 0, 0, cur_div);
        idle(5);

        // Reset mid-run at o_cnt=42.
        cyc(0, 1, 0, 0, 0, 100, cur_div);
        idle(42);
        cyc(1, 0, 0, 0, 0, 0, cur_div);
        idle(3);

        // Start+stop together in RUN; zero-limit start in IDLE.
        cyc(0, 1, 0, 0, 1, 20, cur_div);
        idle(7);
        cyc(0, 1, 1, 0, 1, 30, cur_div);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0, cur_div);
        idle(3);

        // L=1 in both modes, and restart from DONE with a new limit.
        cyc(0, 1, 0, 0, 1, 1, cur_div);
        idle(5);
        cyc(0, 1, 0, 0, 0, 1, cur_div);
        idle(4);
        cyc(0, 1, 0, 0, 0, 127, cur_div);
        idle(130);
        cyc(0, 1, 0, 0, 1, 3, cur_div);
        idle(8);

`ifdef COUNTER_CTRL_PRESCALE_EN
        // Prescaled periodic run: div=3, L=4.
        cur_div = 3;
        cyc(0, 0, 1, 0, 0, 0, cur_div);
        cyc(0, 1, 0, 0, 1, 4, cur_div);
        idle(40);
        cur_div = 0;
        cyc(0, 0, 1, 0, 0, 0, cur_div);
`endif

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            rr = ($urandom_range(0, 299) == 0);
            pp = ($urandom_range(0, 119) == 0);
            ss = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) hold_lvl = ~hold_lvl;
            case ($urandom_range(0, 5))
                0:       lim = 0;
                1:       lim = $urandom_range(1, 127);
                default: lim = $urandom_range(1, 8);
            endcase
            if (rr || pp) cur_div = $urandom_range(0, 3);
            cyc(rr, ss, pp, hold_lvl, 1'($urandom_range(0, 1)), lim, cur_div);
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
